// File: rtl/ahblite_iq_fetch_engine.sv
// Instruction-queue fetch engine: on a fetch_en rising edge, streams fetch_len words from a
// 1-cycle-latency instruction SRAM into a first-word-fall-through FIFO drained by the decoder.
module ahblite_iq_fetch_engine #(
   parameter int MEM_AW = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int LEN_W  = 10
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic                     fetch_en,
   input  logic [MEM_AW-1:0]        base_addr,
   input  logic [LEN_W-1:0]         fetch_len,
   output logic                     mem_rd_en,
   output logic [MEM_AW-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     iq_valid,
   output logic [DATA_W-1:0]        iq_data,
   input  logic                     iq_ready,
   output logic [$clog2(DEPTH):0]   iq_count,
   output logic                     busy,
   output logic                     done
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t            state, state_nx;
   logic              fetch_en_d;
   logic              rd_pend;
   logic [MEM_AW-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW:0]       count;
   logic [DATA_W-1:0] queue [DEPTH];

   logic start, push, pop, space_ok;

   assign start = fetch_en & ~fetch_en_d;
   assign push  = rd_pend;
   assign pop   = iq_valid & iq_ready;

   // The in-flight read reserves a slot; a same-cycle pop is not credited, so a push never overflows.
   assign space_ok = ({1'b0, count} + {{(PW+1){1'b0}}, rd_pend}) < (PW+2)'(DEPTH);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx  = state;
      mem_rd_en = 1'b0;
      busy      = (state != IDLE);
      done      = (state == DONE);
      unique case (state)
         IDLE: begin
            if (start) state_nx = (fetch_len != '0) ? FETCH : DONE;
         end
         FETCH: begin
            mem_rd_en = (remaining != '0) & space_ok;
            if (mem_rd_en && remaining == LEN_W'(1)) state_nx = DRAIN;
         end
         DRAIN: begin
            if (rd_pend) state_nx = DONE;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state      <= IDLE;
         fetch_en_d <= 1'b0;
         addr       <= '0;
         remaining  <= '0;
         rd_pend    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         state      <= state_nx;
         fetch_en_d <= fetch_en;
         rd_pend    <= mem_rd_en;

         if (state == IDLE && start && fetch_len != '0) begin
            addr      <= base_addr;
            remaining <= fetch_len;
         end else if (mem_rd_en) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
         end

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // NOTE: queue storage is not reset; count and pointers define validity and iq_data is masked when empty.
   always_ff @(posedge HCLK) begin
      if (HRESETn && push) queue[wr_ptr] <= mem_rdata;
   end

   assign mem_addr = addr;
   assign iq_count = count;
   assign iq_valid = (count != '0);
   assign iq_data  = iq_valid ? queue[rd_ptr] : '0;

endmodule

// File: tb/tb_ahblite_iq_fetch_engine.sv
// Self-checking bench for ahblite_iq_fetch_engine: directed vector table, corner-case sequences
// and randomized fetches, all checked by a queue-based model of the fetch/queue rules.
module tb_ahblite_iq_fetch_engine;

   localparam int MEM_AW = 10;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int LEN_W  = 10;

   logic                   HCLK = 1'b0;
   logic                   HRESETn = 1'b0;
   logic                   fetch_en = 1'b0;
   logic [MEM_AW-1:0]      base_addr = '0;
   logic [LEN_W-1:0]       fetch_len = '0;
   logic                   mem_rd_en;
   logic [MEM_AW-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_rdata = '0;
   logic                   iq_valid;
   logic [DATA_W-1:0]      iq_data;
   logic                   iq_ready = 1'b0;
   logic [$clog2(DEPTH):0] iq_count;
   logic                   busy;
   logic                   done;

   ahblite_iq_fetch_engine #(
      .MEM_AW(MEM_AW), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .fetch_en(fetch_en), .base_addr(base_addr),
      .fetch_len(fetch_len), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .iq_valid(iq_valid), .iq_data(iq_data), .iq_ready(iq_ready), .iq_count(iq_count),
      .busy(busy), .done(done)
   );

   always #5 HCLK = ~HCLK;

   logic [DATA_W-1:0] sram [1 << MEM_AW];
   always @(posedge HCLK) if (mem_rd_en) mem_rdata <= sram[mem_addr];

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: words owed to the queue, occupancy, outstanding read, fetch bookkeeping.
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] m_pend_data;
   logic [MEM_AW-1:0] m_addr;
   int  m_occ = 0, m_pend = 0, m_left = 0;
   bit  m_fetching = 0, m_busy = 0, m_done = 0, m_fe_prev = 0;
   bit  m_live = 0, m_zero = 0, exp_rd = 0, last_push = 0, nxt_done = 0;
   int  n_reads = 0, n_pops = 0;
   logic [MEM_AW-1:0] first_addr = '0, last_addr = '0;

   always @(negedge HCLK) begin
      if (m_live) begin
         exp_rd = m_fetching && (m_left > 0) && (m_occ + m_pend < DEPTH);
         check("busy", busy, m_busy);
         check("done", done, m_done);
         check("mem_rd_en", mem_rd_en, exp_rd);
         if (exp_rd) check("mem_addr", mem_addr, m_addr);
         check("iq_count", iq_count, m_occ);
         check("iq_valid", iq_valid, m_occ != 0);
         if (m_occ != 0) check("iq_data", iq_data, exp_q[0]);
         if (m_zero) begin
            check("rst_mem_addr", mem_addr, 0);
            check("rst_iq_data", iq_data, 0);
         end
         if (mem_rd_en) begin
            n_reads++;
            if (n_reads == 1) first_addr = mem_addr;
            last_addr = mem_addr;
         end
         if (iq_valid && iq_ready) n_pops++;
      end
      if (!HRESETn) begin
         exp_q.delete();
         m_occ = 0; m_pend = 0; m_left = 0;
         m_fetching = 0; m_busy = 0; m_done = 0; m_fe_prev = 0;
         m_live = 1; m_zero = 1; exp_rd = 0;
      end else if (m_live) begin
         m_zero = 0;
         if (m_occ != 0 && iq_ready) begin
            void'(exp_q.pop_front());
            m_occ--;
         end
         last_push = (m_pend != 0);
         if (last_push) begin
            exp_q.push_back(m_pend_data);
            m_occ++;
         end
         m_pend = 0;
         if (exp_rd) begin
            m_pend = 1;
            m_pend_data = sram[m_addr];
            m_addr = m_addr + 1'b1;
            m_left--;
         end
         nxt_done = 0;
         if (m_fetching && m_left == 0 && !exp_rd && last_push) begin
            nxt_done = 1;
            m_fetching = 0;
         end
         if (fetch_en && !m_fe_prev && !m_busy) begin
            if (fetch_len != '0) begin
               m_fetching = 1;
               m_left = int'(fetch_len);
               m_addr = base_addr;
            end else begin
               nxt_done = 1;
            end
         end
         m_fe_prev = fetch_en;
         m_done = nxt_done;
         m_busy = m_fetching || nxt_done;
      end
   end

   bit rand_ready = 0;

   task automatic tick();
      @(posedge HCLK);
      #1;
      if (rand_ready) iq_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic wait_done(input int budget, output int dc);
      dc = -1;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (done) begin
            dc = k;
            break;
         end
      end
      check("done_seen", dc >= 0, 1);
   endtask

   task automatic run_fetch(input logic [MEM_AW-1:0] b, input int l, input int budget, output int dc);
      fetch_en = 1'b0;
      tick();
      base_addr = b;
      fetch_len = LEN_W'(l);
      fetch_en  = 1'b1;
      n_reads   = 0;
      wait_done(budget, dc);
      fetch_en = 1'b0;
   endtask

   task automatic drain();
      rand_ready = 0;
      iq_ready = 1'b1;
      for (int k = 0; k < 40 && iq_count != 0; k++) tick();
      check("drain_empty", iq_count, 0);
   endtask

   typedef struct {
      logic [MEM_AW-1:0] base;
      int                len;
      int                exp_reads;
      logic [MEM_AW-1:0] exp_first;
      logic [MEM_AW-1:0] exp_last;
      int                exp_done_cyc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int dc;
      bit saw_done;
      logic [MEM_AW-1:0] rb;
      int rl;

      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      bit saw_done;
      logic [MEM_AW-1:0] rb;
      int rl;

      // done appears in cycle len+1 after the start edge (cycle 0 when len==0), queue never stalls.
      vecs[0] = '{10'h010,  4,  4, 10'h010, 10'h013,  5};
      vecs[1] = '{10'h3FE,  4,  4, 10'h3FE, 10'h001,  5};
      vecs[2] = '{10'h123,  0,  0, 10'h000, 10'h000,  0};
      vecs[3] = '{10'h200,  1,  1, 10'h200, 10'h200,  2};
      vecs[4] = '{10'h3FF,  9,  9, 10'h3FF, 10'h007, 10};
      vecs[5] = '{10'h0A0, 16, 16, 10'h0A0, 10'h0AF, 17};

      for (int i = 0; i < (1 << MEM_AW); i++) sram[i] = 32'hA000_0000 + i;

      HRESETn = 1'b0;
      repeat (3) tick();
      check("reset_busy", busy, 0);
      check("reset_iq_count", iq_count, 0);
      check("reset_iq_valid", iq_valid, 0);
      check("reset_mem_rd_en", mem_rd_en, 0);
      check("reset_done", done, 0);
      check("reset_mem_addr", mem_addr, 0);
      HRESETn = 1'b1;
      tick();

      iq_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run_fetch(vecs[i].base, vecs[i].len, 100, dc);
         check($sformatf("v%0d_done_cyc", i), dc, vecs[i].exp_done_cyc);
         check($sformatf("v%0d_reads", i), n_reads, vecs[i].exp_reads);
         if (vecs[i].exp_reads != 0) begin
            check($sformatf("v%0d_first_addr", i), first_addr, vecs[i].exp_first);
            check($sformatf("v%0d_last_addr", i), last_addr, vecs[i].exp_last);
         end
         tick();
         check($sformatf("v%0d_busy_after", i), busy, 0);
         drain();
      end

      // Queue fills with no consumer: reads stall at DEPTH, then resume once popping starts.
      iq_ready = 1'b0;
      fetch_en = 1'b0;
      tick();
      base_addr = 10'h100;
      fetch_len = 10'd12;
      fetch_en  = 1'b1;
      n_reads = 0;
      n_pops  = 0;
      repeat (20) tick();
      check("stall_reads", n_reads, 8);
      check("stall_count", iq_count, 8);
      check("stall_rd_en", mem_rd_en, 0);
      check("stall_busy", busy, 1);
      iq_ready = 1'b1;
      wait_done(60, dc);
      fetch_en = 1'b0;
      drain();
      check("stall_total_reads", n_reads, 12);
      check("stall_total_pops", n_pops, 12);

      // A second rise during FETCH is ignored; a held level does not restart; a fresh rise does.
      fetch_en = 1'b0;
      tick();
      base_addr = 10'h050;
      fetch_len = 10'd6;
      fetch_en  = 1'b1;
      n_reads = 0;
      tick();
      tick();
      fetch_en = 1'b0;
      tick();
      base_addr = 10'h300;
      fetch_len = 10'd3;
      fetch_en  = 1'b1;
      wait_done(40, dc);
      check("restart_ignored_reads", n_reads, 6);
      check("restart_ignored_last", last_addr, 10'h055);
      repeat (6) tick();
      check("held_no_restart_busy", busy, 0);
      check("held_no_restart_reads", n_reads, 6);
      fetch_en = 1'b0;
      tick();
      fetch_en = 1'b1;
      n_reads = 0;
      wait_done(40, dc);
      check("retoggle_reads", n_reads, 3);
      check("retoggle_first", first_addr, 10'h300);
      fetch_en = 1'b0;
      drain();

      // Reset mid-fetch with three words queued aborts everything and never pulses done.
      iq_ready = 1'b0;
      fetch_en = 1'b0;
      tick();
      base_addr = 10'h020;
      fetch_len = 10'd10;
      fetch_en  = 1'b1;
      for (int k = 0; k < 20 && iq_count != 3; k++) tick();
      check("abort_three_queued", iq_count, 3);
      check("abort_busy_before", busy, 1);
      HRESETn  = 1'b0;
      fetch_en = 1'b0;
      tick();
      check("abort_iq_valid", iq_valid, 0);
      check("abort_iq_count", iq_count, 0);
      check("abort_busy", busy, 0);
      check("abort_rd_en", mem_rd_en, 0);
      check("abort_done", done, 0);
      HRESETn = 1'b1;
      saw_done = 0;
      repeat (6) begin
         tick();
         saw_done |= done;
      end
      check("abort_no_done", saw_done, 0);

      // Randomized fetches with a random consumer; back-to-back starts append behind queued words.
      rand_ready = 1;
      for (int r = 0; r < 30; r++) begin
         rb = MEM_AW'($urandom);
         rl = $urandom_range(0, 20);
         run_fetch(rb, rl, 400, dc);
         check($sformatf("rnd%0d_reads", r), n_reads, rl);
         if (rl != 0) check($sformatf("rnd%0d_first", r), first_addr, rb);
         repeat ($urandom_range(0, 3)) tick();
      end
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
